// File: rtl/rtc_write_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rtc_write_sequencer_pkg
// Description : Shared definitions for the RTC write path. Holds the
//               sequencer state encoding, the register index map and the
//               decoder address of the final commit command, so that the
//               address decoder and the sequencer use one index map.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_write_sequencer_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_REQ   = 3'd2,
        ST_NEXT  = 3'd3,
        ST_FIN   = 3'd4
    } seq_state_t;

    // Register index map. This is the value driven on the decoder's binary_in.
    localparam logic [3:0] IDX_SEC   = 4'd0;
    localparam logic [3:0] IDX_MIN   = 4'd1;
    localparam logic [3:0] IDX_HOUR  = 4'd2;
    localparam logic [3:0] IDX_DAY   = 4'd3;
    localparam logic [3:0] IDX_MONTH = 4'd4;
    localparam logic [3:0] IDX_YEAR  = 4'd5;
    localparam logic [3:0] IDX_TSEC  = 4'd6;
    localparam logic [3:0] IDX_TMIN  = 4'd7;
    localparam logic [3:0] IDX_THOUR = 4'd8;
    localparam logic [3:0] IDX_CTRL  = 4'd9;
    localparam logic [3:0] IDX_CMD   = 4'd10;

    // Number of snapshot bytes (indices IDX_SEC..IDX_CTRL).
    localparam int NUM_SNAP_BYTES = 10;

    // Decoder address produced for the final transfer/commit command.
    localparam logic [7:0] ADDR_CMD = 8'hF0;

    // Data byte carried by the commit command.
    localparam logic [7:0] CMD_DATA = 8'h00;

endpackage : rtc_write_sequencer_pkg
`default_nettype wire

// File: rtl/rtc_wr_data_mux.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rtc_wr_data_mux
// Description : Combinational selector from a 10-byte snapshot and a register
//               index to the byte written at that index. The commit index and
//               the unused indices 11..15 yield 0x00.
// Ports       : snap_bytes [79:0] in  - byte i at bits [8*i+7:8*i]
//               idx        [3:0]  in  - register index
//               wr_data    [7:0]  out - byte for idx
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_wr_data_mux
    import rtc_write_sequencer_pkg::*;
(
    input  logic [79:0] snap_bytes,
    input  logic [3:0]  idx,
    output logic [7:0]  wr_data
);

    always_comb begin
        wr_data = CMD_DATA;
        case (idx)
            IDX_SEC:   wr_data = snap_bytes[ 7: 0];
            IDX_MIN:   wr_data = snap_bytes[15: 8];
            IDX_HOUR:  wr_data = snap_bytes[23:16];
            IDX_DAY:   wr_data = snap_bytes[31:24];
            IDX_MONTH: wr_data = snap_bytes[39:32];
            IDX_YEAR:  wr_data = snap_bytes[47:40];
            IDX_TSEC:  wr_data = snap_bytes[55:48];
            IDX_TMIN:  wr_data = snap_bytes[63:56];
            IDX_THOUR: wr_data = snap_bytes[71:64];
            IDX_CTRL:  wr_data = snap_bytes[79:72];
            default:   wr_data = CMD_DATA;
        endcase
    end

endmodule : rtc_wr_data_mux
`default_nettype wire

// File: rtl/rtc_write_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rtc_write_sequencer
// Description : Snapshots the RTC time/timer/control bytes on start and
//               issues one request/acknowledge write per register index
//               0..LAST_IDX, presenting index, decoder enable and data. The
//               last index is the commit command. Reports busy, a one-cycle
//               done pulse and a sticky timeout error.
// Ports       : clk, rst_n (async active-low)
//               start                      in  - begin a burst (dropped if busy)
//               bus_ack                    in  - bus cycle complete
//               sec_in..year_in            in  - BCD clock/date bytes
//               tsec_in, tmin_in, thour_in in  - BCD timer bytes
//               ctrl_in                    in  - control register byte
//               idx, idx_en                out - decoder index and enable
//               wr_data                    out - byte for current index
//               bus_req                    out - request one bus write
//               busy, done, err            out - status
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_write_sequencer
    import rtc_write_sequencer_pkg::*;
#(
    parameter int LAST_IDX    = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bus_ack,
    input  logic [7:0] sec_in,
    input  logic [7:0] min_in,
    input  logic [7:0] hour_in,
    input  logic [7:0] day_in,
    input  logic [7:0] month_in,
    input  logic [7:0] year_in,
    input  logic [7:0] tsec_in,
    input  logic [7:0] tmin_in,
    input  logic [7:0] thour_in,
    input  logic [7:0] ctrl_in,
    output logic [3:0] idx,
    output logic       idx_en,
    output logic [7:0] wr_data,
    output logic       bus_req,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] C_LAST_IDX = 4'(LAST_IDX);
    // The abort fires on the REQ edge at which the counter would reach
    // TIMEOUT_CYC, i.e. when it currently holds TIMEOUT_CYC-1.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYC - 1);

    seq_state_t  r_state;
    logic [79:0] r_snap;
    logic [3:0]  r_idx;
    logic        r_idx_en;
    logic [7:0]  r_wr_data;
    logic        r_bus_req;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_tmo_cnt;

    logic [79:0] w_live_bytes;
    logic [79:0] w_mux_bytes;
    logic [3:0]  w_mux_idx;
    logic [7:0]  w_mux_data;

    assign w_live_bytes = {ctrl_in, thour_in, tmin_in, tsec_in, year_in,
                           month_in, day_in, hour_in, min_in, sec_in};

    // wr_data is registered so that it is already valid in SETUP. The mux
    // therefore looks at the byte for the index being entered: the live
    // inputs at idx 0 when a burst is accepted, otherwise the snapshot at
    // idx+1 when stepping out of NEXT.
    assign w_mux_bytes = (r_state == ST_IDLE) ? w_live_bytes : r_snap;
    assign w_mux_idx   = (r_state == ST_IDLE) ? IDX_SEC : (r_idx + 4'd1);

    rtc_wr_data_mux u_wr_data_mux (
        .snap_bytes (w_mux_bytes),
        .idx        (w_mux_idx),
        .wr_data    (w_mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_idx     <= 4'd0;
            r_idx_en  <= 1'b0;
            r_wr_data <= 8'h00;
            r_bus_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo_cnt <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap    <= w_live_bytes;
                        r_err     <= 1'b0;
                        r_idx     <= IDX_SEC;
                        r_idx_en  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wr_data <= w_mux_data;
                        r_state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_bus_req <= 1'b1;
                    r_tmo_cnt <= 8'd0;
                    r_state   <= ST_REQ;
                end

                ST_REQ: begin
                    // An ack on the timeout edge still counts as success.
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_NEXT;
                    end else if (r_tmo_cnt == C_TMO_LAST) begin
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_idx_en  <= 1'b0;
                        r_bus_req <= 1'b0;
                        r_idx     <= 4'd0;
                        r_wr_data <= 8'h00;
                        r_tmo_cnt <= 8'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end

                ST_NEXT: begin
                    r_tmo_cnt <= 8'd0;
                    if (r_idx == C_LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_idx     <= r_idx + 4'd1;
                        r_wr_data <= w_mux_data;
                        r_state   <= ST_SETUP;
                    end
                end

                ST_FIN: begin
                    r_busy    <= 1'b0;
                    r_idx_en  <= 1'b0;
                    r_idx     <= 4'd0;
                    r_wr_data <= 8'h00;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign idx     = r_idx;
    assign idx_en  = r_idx_en;
    assign wr_data = r_wr_data;
    assign bus_req = r_bus_req;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule : rtc_write_sequencer
`default_nettype wire

// File: tb/tb_rtc_write_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rtc_write_sequencer
// Description : Self-checking bench for rtc_write_sequencer. A table of burst
//               scenarios plus randomized bursts are run against a transfer
//               list model: expected bytes come from the input bytes by index,
//               expected done latency is the sum of (wait + 3) per index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_write_sequencer;

    localparam int LAST = 10;
    localparam int TMO  = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bus_ack = 1'b0;
    logic [7:0] sec_in = 8'h00, min_in = 8'h00, hour_in = 8'h00, day_in = 8'h00;
    logic [7:0] month_in = 8'h00, year_in = 8'h00, tsec_in = 8'h00;
    logic [7:0] tmin_in = 8'h00, thour_in = 8'h00, ctrl_in = 8'h00;
    logic [3:0] idx;
    logic       idx_en;
    logic [7:0] wr_data;
    logic       bus_req, busy, done, err;

    rtc_write_sequencer #(.LAST_IDX(LAST), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus_ack  (bus_ack),
        .sec_in   (sec_in),
        .min_in   (min_in),
        .hour_in  (hour_in),
        .day_in   (day_in),
        .month_in (month_in),
        .year_in  (year_in),
        .tsec_in  (tsec_in),
        .tmin_in  (tmin_in),
        .thour_in (thour_in),
        .ctrl_in  (ctrl_in),
        .idx      (idx),
        .idx_en   (idx_en),
        .wr_data  (wr_data),
        .bus_req  (bus_req),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int waits[11];

    typedef struct {
        logic [79:0] bytes;     // byte i (idx i) at bits [8*i+7:8*i]
        int          wait_cyc;  // ack delay for every request
        int          hang_idx;  // index never acked, -1 for none
        bit          poke;      // change sec_in and re-pulse start mid-burst
        int          exp_lat;   // expected edges from start to done, -1 if none
        bit          exp_err;   // err at end of scenario
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_bytes(input logic [79:0] b);
        sec_in   = b[ 7: 0];
        min_in   = b[15: 8];
        hour_in  = b[23:16];
        day_in   = b[31:24];
        month_in = b[39:32];
        year_in  = b[47:40];
        tsec_in  = b[55:48];
        tmin_in  = b[63:56];
        thour_in = b[71:64];
        ctrl_in  = b[79:72];
    endtask

    function automatic logic [7:0] exp_byte(input logic [79:0] b, input int i);
        if (i < 10) return b[8*i +: 8];
        return 8'h00;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_idx"},     {28'd0, idx}, 32'd0);
        chk({tag, "_idx_en"},  {31'd0, idx_en}, 32'd0);
        chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
        chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
        chk({tag, "_done"},    {31'd0, done}, 32'd0);
        chk({tag, "_err"},     {31'd0, err}, 32'd0);
    endtask

    // Runs one burst from the start pulse to its end (done + 1 cycle, or abort).
    // exp_lat < 0 means the latency is taken from the per-index wait model.
    task automatic run_burst(input logic [79:0] b, input int hang_idx, input bit noise,
                             input bit poke, input int exp_lat);
        int n, rc, k, lat, dones;
        logic [3:0] h_idx;
        logic [7:0] h_dat;
        bit fin;
        lat = 0;
        for (int i = 0; i <= LAST; i++) lat += waits[i] + 3;
        if (exp_lat >= 0) lat = exp_lat;
        h_idx = 4'd0;
        h_dat = 8'h00;
        drive_bytes(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; rc = 0; k = 0; dones = 0; fin = 1'b0;
        while (!fin) begin
            if (done) begin
                dones++;
                chk("done_latency", k, lat);
                chk("busy_in_fin", {31'd0, busy}, 32'd1);
                chk("requests_issued", n, LAST + 1);
            end else if (dones > 0) begin
                chk("done_once", dones, 1);
                chk("busy_after", {31'd0, busy}, 32'd0);
                chk("idx_en_after", {31'd0, idx_en}, 32'd0);
                chk("idx_after", {28'd0, idx}, 32'd0);
                fin = 1'b1;
            end
            if (bus_req) begin
                if (rc == 0) begin
                    chk("req_idx", {28'd0, idx}, n);
                    chk("req_wr_data", {24'd0, wr_data}, {24'd0, exp_byte(b, n)});
                    chk("req_idx_en", {31'd0, idx_en}, 32'd1);
                    chk("req_busy", {31'd0, busy}, 32'd1);
                    h_idx = idx;
                    h_dat = wr_data;
                end else begin
                    chk("hold_stable", {20'd0, idx, wr_data}, {20'd0, h_idx, h_dat});
                end
                rc++;
                bus_ack = (n <= LAST) && (n != hang_idx) && (rc == waits[n] + 1);
            end else begin
                if (rc > 0) begin
                    if (n == hang_idx) begin
                        chk("timeout_req_cycles", rc, TMO);
                        chk("timeout_err", {31'd0, err}, 32'd1);
                        chk("timeout_busy", {31'd0, busy}, 32'd0);
                        chk("timeout_idx_en", {31'd0, idx_en}, 32'd0);
                        chk("timeout_idx", {28'd0, idx}, 32'd0);
                        chk("timeout_no_done", dones, 0);
                        fin = 1'b1;
                    end else begin
                        chk("req_cycles", rc, waits[n] + 1);
                        n++;
                    end
                    rc = 0;
                end
                bus_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (poke && k == 0) begin
                sec_in = 8'h59;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!fin) begin
                @(negedge clk);
                k++;
                if (k > 6000) begin
                    chk("burst_bound", k, 0);
                    fin = 1'b1;
                end
            end
        end
        bus_ack = 1'b0;
        start   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] rnd;
        int          cnt;

        // Reset behaviour
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("idle");

        // Scenario table
        vecs[0] = '{80'h00_01_05_10_16_04_26_12_30_45, 0, -1, 1'b0, 33, 1'b0};
        vecs[1] = '{80'h80_23_59_59_99_12_31_23_59_59, 4, -1, 1'b0, 77, 1'b0};
        vecs[2] = '{80'h00_01_05_10_16_04_26_12_30_45, 0, -1, 1'b1, 33, 1'b0};
        vecs[3] = '{80'h00_01_05_10_16_04_26_12_30_45, 0,  3, 1'b0, -1, 1'b1};
        vecs[4] = '{80'h5A_11_22_33_44_55_66_77_88_99, 0, -1, 1'b0, 33, 1'b0};
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i <= LAST; i++) waits[i] = vecs[v].wait_cyc;
            run_burst(vecs[v].bytes, vecs[v].hang_idx, 1'b0, vecs[v].poke, vecs[v].exp_lat);
            chk("final_err", {31'd0, err}, {31'd0, vecs[v].exp_err});
            repeat (2) @(negedge clk);
        end

        // Randomized bursts with random wait states and ack noise outside REQ
        for (int r = 0; r < 6; r++) begin
            rnd = {$urandom, $urandom, $urandom};
            for (int i = 0; i <= LAST; i++) waits[i] = int'($urandom_range(0, 5));
            run_burst(rnd[79:0], -1, 1'b1, 1'b0, -1);
            chk("rand_err", {31'd0, err}, 32'd0);
            repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end

        // Async reset while requesting idx 5
        for (int i = 0; i <= LAST; i++) waits[i] = 0;
        drive_bytes(80'h00_01_05_10_16_04_26_12_30_45);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(bus_req && idx == 4'd5) && cnt < 200) begin
            bus_ack = bus_req;
            @(negedge clk);
            cnt++;
        end
        bus_ack = 1'b0;
        chk("reach_idx5", {31'd0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(80'h00_01_05_10_16_04_26_12_30_45, -1, 1'b0, 1'b0, 33);
        chk("post_reset_err", {31'd0, err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_rtc_write_sequencer
`default_nettype wire
